dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
// - Data-memory responder (target end) of the core's load/store port: accepts one request at a time from the
//   core's LSU over a valid/ready request channel and returns one response over a valid/ready response channel.
// - Word-organised RAM with byte-lane writes, RV32 load sign/zero extension and a fixed access latency.
// - Models multi-cycle memory so the core's stall/handshake logic can be exercised.
// PARAMETERS
// - DEPTH   256  number of 32-bit words; power of two, >=4
// - LATENCY 2    cycles from request accept to resp_valid high; legal range 1..15
// PORTS
// - clk         in   1   clock, rising edge
// - rst         in   1   asynchronous, active-high reset
// - req_valid   in   1   request present
// - req_ready   out  1   responder can accept; high only in IDLE
// - req_we      in   1   1=store, 0=load
// - req_size    in   3   RV32 func3: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); stores use 000/001/010
// - req_addr    in   32  byte address
// - req_wdata   in   32  store data, right-aligned (byte in [7:0], half in [15:0])
// - resp_valid  out  1   response present
// - resp_ready  in   1   core accepts response
// - resp_rdata  out  32  load data, extended to 32 bits; 0 for stores
// - resp_err    out  1   access fault (misalign check only; see CONFIGURATION)
// BEHAVIOUR
// - Reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0. RAM contents not reset.
// - FSM: IDLE -> WAIT on accept (req_valid & req_ready); WAIT -> RESP when counter expires; RESP -> IDLE on resp_valid & resp_ready.
// - Accept captures we/size/addr/wdata; inputs are don't-care afterwards until the next accept.
// - Latency: resp_valid rises exactly LATENCY cycles after the accept edge. LATENCY=1: WAIT lasts one cycle.
// - The RAM write and read happen on the WAIT->RESP edge; a read in the same access returns pre-write data (N/A, one op per access).
// - RESP: resp_valid/resp_rdata/resp_err held stable until handshake; no new accept in the handshake cycle (req_ready=0 in RESP).
//   Maximum throughput is one access per LATENCY+2 cycles.
// - Indexing: word = addr[$clog2(DEPTH)+1:2]; higher address bits ignored (aliasing/wrap-around, no fault).
// - Lanes: byte lane = addr[1:0]; half lane = addr[1] (bytes {1,0} or {3,2}); word = all four bytes.
// - Stores: SB writes one byte from wdata[7:0]; SH writes two bytes from wdata[15:0]; SW writes all four. Other bytes unchanged.
// - Loads: B/H sign-extend the selected lane; BU/HU zero-extend it; W returns the word.
// - req_size 011/110/111: treated as W (load or store).
// - Reset mid-access (WAIT or RESP): abort immediately; a store not yet at the WAIT->RESP edge is not written.
// - Idle outputs: resp_rdata and resp_err keep their last value when resp_valid=0; the bench ignores them.
// CONFIGURATION
// - Macro DMEM_MISALIGN_CHK_EN
//   - Defined: H/HU with addr[0]=1, or W with addr[1:0]!=0, completes with normal latency, resp_err=1, resp_rdata=0, RAM not written.
//   - Undefined: no check. Ignored low bits are dropped (H uses addr[1] only; W ignores addr[1:0]). resp_err is tied 0.
// TESTING
// - Reset, LATENCY=2: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> resp_valid 2 cycles after each accept; rdata=0xDEADBEEF.
// - SB addr 0x13 data 0x80 over 0xDEADBEEF, then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80ADBEEF.
// - LH 0x12 -> 0xFFFF80AD; LHU 0x12 -> 0x000080AD; LH 0x10 -> 0xFFFFBEEF.
// - Hold resp_ready=0 for 5 cycles in RESP -> resp_valid/rdata stable, req_ready=0 throughout.
//   req_ready=1 the cycle after the handshake.
// - SW 0x20 data 0x11223344, then assert rst during WAIT -> outputs return to reset values; LW 0x20 returns old contents, not 0x11223344.
// - DMEM_MISALIGN_CHK_EN: LW 0x12 -> resp_err=1, rdata=0; SH 0x11 -> resp_err=1, memory unchanged. Without the macro, LW 0x12 returns word 0x10.
// - Aliasing, DEPTH=256: SW 0x400 data 0xA5A5A5A5, then LW 0x000 -> 0xA5A5A5A5.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one valid/ready request in, one response out after LATENCY cycles.
// Optional misalignment fault checking is enabled by defining DMEM_MISALIGN_CHK_EN.
module dmem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [2:0]    size_q, size_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          req_ready_q, req_ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [31:0]   mem_q [DEPTH];

  logic [AW-1:0] idx_c;
  logic [1:0]    lane_c;
  logic          is_byte_c, is_half_c, signed_c;
  logic [31:0]   word_c;
  logic [7:0]    byte_c;
  logic [15:0]   half_c;
  logic [31:0]   load_data_c;
  logic [3:0]    be_c;
  logic [31:0]   mem_wdata_c;
  logic          misalign_c;
  logic          mem_we_c;
  logic          unused_addr_c;

  // High address bits alias onto the RAM and are intentionally dropped.
  assign unused_addr_c = ^req_addr[31:AW+2];

  // Lane selection, load extension and store byte-enable generation
  always_comb begin
    idx_c       = addr_q[AW+1:2];
    lane_c      = addr_q[1:0];
    is_byte_c   = (size_q[1:0] == 2'b00);
    is_half_c   = (size_q[1:0] == 2'b01);
    signed_c    = ~size_q[2];
    word_c      = mem_q[idx_c];
    byte_c      = word_c[{lane_c, 3'b000} +: 8];
    half_c      = addr_q[1] ? word_c[31:16] : word_c[15:0];
    load_data_c = word_c;
    be_c        = 4'b1111;
    mem_wdata_c = wdata_q;
    if (is_byte_c) begin
      load_data_c = signed_c ? {{24{byte_c[7]}}, byte_c} : {24'h0, byte_c};
      be_c        = 4'(4'b0001 << lane_c);
      mem_wdata_c = {4{wdata_q[7:0]}};
    end else if (is_half_c) begin
      load_data_c = signed_c ? {{16{half_c[15]}}, half_c} : {16'h0, half_c};
      be_c        = addr_q[1] ? 4'b1100 : 4'b0011;
      mem_wdata_c = {2{wdata_q[15:0]}};
    end
`ifdef DMEM_MISALIGN_CHK_EN
    misalign_c = (is_half_c && addr_q[0]) ||
                 (!is_byte_c && !is_half_c && (addr_q[1:0] != 2'b00));
`else
    misalign_c = 1'b0;
`endif
  end

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    mem_we_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d = S_WAIT;
          cnt_d   = CW'(LATENCY - 1);
          we_d    = req_we;
          size_d  = req_size;
          addr_d  = req_addr[AW+1:0];
          wdata_d = req_wdata;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d  = S_RESP;
          rdata_d  = (we_q || misalign_c) ? 32'h0 : load_data_c;
          err_d    = misalign_c;
          mem_we_c = we_q && !misalign_c;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      size_q       <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'h0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // RAM is not reset; a store only lands on the WAIT->RESP edge
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) mem_q[idx_c][8*b +: 8] <= mem_wdata_c[8*b +: 8];
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: byte-array reference model, randomized and directed accesses.
module tb_dmem_responder;

  localparam int unsigned DEPTH   = 256;
  localparam int unsigned LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_size = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem_m [DEPTH][4];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  int         rr_mode = 0;   // 0 random, 1 always ready, 2 hold low
  bit         in_resp = 1'b0;
  bit         ready_next = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endfunction

  // Reference model: byte-granular memory with access semantics computed arithmetically
  function automatic void model(input bit we, input logic [2:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    int idx, nbytes, off;
    bit sgn;
    longint v;
    idx = int'((addr >> 2) % DEPTH);
    case (size)
      3'b000: begin nbytes = 1; sgn = 1; end
      3'b100: begin nbytes = 1; sgn = 0; end
      3'b001: begin nbytes = 2; sgn = 1; end
      3'b101: begin nbytes = 2; sgn = 0; end
      default: begin nbytes = 4; sgn = 0; end
    endcase
    off = (nbytes == 1) ? int'(addr % 4) : (nbytes == 2) ? int'(addr % 4) / 2 * 2 : 0;
    err = 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
    if (addr % nbytes != 0) err = 1'b1;
`endif
    rdata = 32'h0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < nbytes; i++) mem_m[idx][off + i] = 8'(wdata >> (8 * i));
    end else begin
      v = 0;
      for (int i = 0; i < nbytes; i++) v += longint'(mem_m[idx][off + i]) << (8 * i);
      if (sgn && v >= (longint'(1) << (8 * nbytes - 1))) v -= longint'(1) << (8 * nbytes);
      rdata = 32'(v);
    end
  endfunction

  task automatic do_access(input bit we, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit push);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (!req_ready) begin
      n_chk++;
      $display("FAIL req_ready_timeout: got 0 expected 1 (cycle %0d)", cyc);
      return;
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    if (push) begin
      model(we, size, addr, wdata, e.rdata, e.err);
      e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        1: resp_ready = 1'b1;
        2: resp_ready = 1'b0;
        default: resp_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor: compare every presented response against the scoreboard head
  always @(negedge clk) begin
    if (rst) begin
      in_resp    = 1'b0;
      ready_next = 1'b0;
    end else begin
      if (ready_next) begin
        chk("req_ready_after_hs", 32'(req_ready), 32'h1);
        ready_next = 1'b0;
      end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_resp: got resp_valid 1 expected 0 (cycle %0d)", cyc);
        end else begin
          if (!in_resp) begin
            chk("latency", 32'(cyc - sb[0].acc), 32'(LATENCY));
            in_resp = 1'b1;
          end
          chk("rdata", resp_rdata, sb[0].rdata);
          chk("err", 32'(resp_err), 32'(sb[0].err));
          chk("req_ready_in_resp", 32'(req_ready), 32'h0);
          if (resp_ready) begin
            void'(sb.pop_front());
            in_resp    = 1'b0;
            ready_next = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int n;
    logic [2:0] sz;
    bit we;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", 32'(resp_err), 32'h0);
    rst = 1'b0;

    for (int w = 0; w < 16; w++) do_access(1'b1, 3'b010, 32'(w * 4), $urandom, 1'b1);
    drain();

    do_access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1);
    do_access(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
    do_access(1'b1, 3'b000, 32'h13, 32'h00000080, 1'b1);
    do_access(1'b0, 3'b000, 32'h13, 32'h0, 1'b1);
    do_access(1'b0, 3'b100, 32'h13, 32'h0, 1'b1);
    do_access(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
    do_access(1'b0, 3'b001, 32'h12, 32'h0, 1'b1);
    do_access(1'b0, 3'b101, 32'h12, 32'h0, 1'b1);
    do_access(1'b0, 3'b001, 32'h10, 32'h0, 1'b1);
    drain();

    // Back-pressure: hold resp_ready low for 5 cycles in RESP
    rr_mode = 2;
    do_access(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
    n = 0;
    while (!resp_valid && n < 50) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    rr_mode = 1;
    drain();
    rr_mode = 0;

    do_access(1'b0, 3'b010, 32'h12, 32'h0, 1'b1);
    do_access(1'b1, 3'b001, 32'h11, 32'h0000BEEF, 1'b1);
    do_access(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
    do_access(1'b1, 3'b010, 32'h400, 32'hA5A5A5A5, 1'b1);
    do_access(1'b0, 3'b010, 32'h000, 32'h0, 1'b1);
    do_access(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 1'b1);
    drain();

    // Abort a store with reset while it is still in WAIT
    do_access(1'b1, 3'b010, 32'h20, 32'h11223344, 1'b0);
    rst = 1'b1;
    #1;
    chk("abort_req_ready", 32'(req_ready), 32'h1);
    chk("abort_resp_valid", 32'(resp_valid), 32'h0);
    chk("abort_rdata", resp_rdata, 32'h0);
    chk("abort_err", 32'(resp_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_access(1'b0, 3'b010, 32'h20, 32'h0, 1'b1);
    drain();

    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom);
      if (we) begin
        case ($urandom_range(0, 5))
          0: sz = 3'b000; 1: sz = 3'b001; 2: sz = 3'b010;
          3: sz = 3'b011; 4: sz = 3'b110; default: sz = 3'b111;
        endcase
      end else begin
        sz = 3'($urandom);
      end
      do_access(we, sz,
                ($urandom & ~32'h000003FC) | 32'($urandom_range(0, 15) << 2),
                $urandom, 1'b1);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
